updown_mod_counter: RTL and testbench

- Parametrised successor to the free-running 8-bit counter.
- Features: width and modulus set by parameters; up/down; enable; synchronous load; wrap or saturate; registered terminal-count pulse.
- Optional multi-cycle binary-to-BCD converter produces digits for the seven-segment display path.
- Sits between the clock divider (`slow_clk` domain) and the SSD multiplexer.

---
 rtl/updown_mod_counter.sv | 157 +++++++++++++++
 tb/tb_updown_mod_counter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate and terminal-count pulse.
// Define UPDOWN_BCD_EN to build the multi-cycle binary-to-BCD converter (bcd, bcd_valid).
//   state   | meaning
//   S_IDLE  | wait for count to differ from the last converted value
//   S_SHIFT | double-dabble: WIDTH add-3/shift iterations
//   S_DONE  | publish scratch to bcd, pulse bcd_valid
module updown_mod_counter #(
   parameter int WIDTH   = 8,
   parameter int MOD_MAX = 2**WIDTH-1,
   parameter int DIGITS  = 3
) (
   input  logic             slow_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
`ifdef UPDOWN_BCD_EN
   ,
   output logic [4*DIGITS-1:0] bcd,
   output logic                bcd_valid
`endif
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

   // Saturate mode flags arriving at (or staying at) the boundary; wrap mode flags the wrap itself.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (en) begin
         if (up) begin
            if (count_q != MAX_V) count_d = count_q + ONE_V;
            else if (!sat)        count_d = '0;
            tc_d = sat ? (count_d == MAX_V) : (count_q == MAX_V);
         end else begin
            if (count_q != '0) count_d = count_q - ONE_V;
            else if (!sat)     count_d = MAX_V;
            tc_d = sat ? (count_d == '0) : (count_q == '0);
         end
      end
   end

   always_ff @(posedge slow_clk) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;

`ifdef UPDOWN_BCD_EN
   localparam int IW = $clog2(WIDTH+1);

   if (10**DIGITS <= MOD_MAX) begin : g_bad_digits
      $error("updown_mod_counter: DIGITS too small for MOD_MAX");
   end

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_state_t;

   bcd_state_t          state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [WIDTH-1:0]    cap_q, cap_d;
   logic [WIDTH-1:0]    last_q, last_d;
   logic [IW-1:0]       iter_q, iter_d;
   logic [4*DIGITS-1:0] scratch_q, scratch_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                valid_q, valid_d;
   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cap_d     = cap_q;
      last_d    = last_q;
      iter_d    = iter_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      valid_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != last_q) begin
               cap_d     = count_q;
               shift_d   = count_q;
               scratch_d = '0;
               iter_d    = IW'(WIDTH);
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scratch_d = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
            shift_d   = shift_q << 1;
            iter_d    = iter_q - IW'(1);
            if (iter_q == IW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d   = scratch_q;
            last_d  = cap_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge slow_clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cap_q     <= '0;
         last_q    <= '0;
         iter_q    <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cap_q     <= cap_d;
         last_q    <= last_d;
         iter_q    <= iter_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
      end
   end

   assign bcd       = bcd_q;
   assign bcd_valid = valid_q;
`else
   // DIGITS only matters when the converter is built.
   if (DIGITS < 0) begin : g_unused_digits
   end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: arithmetic reference model plus directed literal checks.
// BCD checks run on a second full-range instance when UPDOWN_BCD_EN is defined.
module tb_updown_mod_counter;

   localparam int MAX = 9;

   logic       slow_clk;
   logic       rst, en, up, sat, load;
   logic [7:0] load_val;
   logic [7:0] count;
   logic       tc;

   int n_checks = 0;
   int n_errors = 0;
   int m_count  = 0;
   int m_tc     = 0;
   bit chk_en   = 0;

`ifdef UPDOWN_BCD_EN
   logic [11:0] bcd;
   logic        bcd_valid;
   logic        b_rst, b_en, b_up, b_sat, b_load;
   logic [7:0]  b_load_val;
   logic [7:0]  b_count;
   logic        b_tc;
   logic [11:0] b_bcd;
   logic        b_bcd_valid;
`endif

   updown_mod_counter #(.WIDTH(8), .MOD_MAX(MAX), .DIGITS(3)) dut (
      .slow_clk (slow_clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc)
`ifdef UPDOWN_BCD_EN
      ,
      .bcd       (bcd),
      .bcd_valid (bcd_valid)
`endif
   );

`ifdef UPDOWN_BCD_EN
   updown_mod_counter #(.WIDTH(8), .MOD_MAX(255), .DIGITS(3)) dut_b (
      .slow_clk  (slow_clk),
      .rst       (b_rst),
      .en        (b_en),
      .up        (b_up),
      .sat       (b_sat),
      .load      (b_load),
      .load_val  (b_load_val),
      .count     (b_count),
      .tc        (b_tc),
      .bcd       (b_bcd),
      .bcd_valid (b_bcd_valid)
   );
`endif

   initial slow_clk = 1'b0;
   always #5 slow_clk = ~slow_clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge slow_clk);
   endtask

   // Reference: step in plain integers, then wrap or clamp anything that left 0..MAX.
   always @(posedge slow_clk) begin
      int raw;
      if (rst) begin
         m_count = 0;
         m_tc    = 0;
      end else if (load) begin
         m_count = (int'(load_val) > MAX) ? MAX : int'(load_val);
         m_tc    = 0;
      end else if (en) begin
         raw = m_count + (up ? 1 : -1);
         if (raw > MAX || raw < 0) begin
            if (sat) m_count = (raw < 0) ? 0 : MAX;
            else     m_count = (raw < 0) ? MAX : 0;
            m_tc = 1;
         end else begin
            m_count = raw;
            m_tc    = (sat && raw == (up ? MAX : 0)) ? 1 : 0;
         end
      end else begin
         m_tc = 0;
      end
   end

   always @(posedge slow_clk) begin
      #1;
      if (chk_en) begin
         n_checks++;
         if (count !== 8'(m_count)) begin
            n_errors++;
            $display("FAIL model_count: got %0d expected %0d (t=%0t)", count, m_count, $time);
         end
         n_checks++;
         if (tc !== 1'(m_tc)) begin
            n_errors++;
            $display("FAIL model_tc: got %0b expected %0d (t=%0t)", tc, m_tc, $time);
         end
      end
   end

`ifdef UPDOWN_BCD_EN
   function automatic int to_bcd(input int v);
      return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   task automatic b_wait(input int limit, output int k);
      k = 0;
      do begin
         @(negedge slow_clk);
         k++;
      end while (!b_bcd_valid && k < limit);
   endtask
`endif

   initial begin
      int exp_wrap[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int exp_ds[5]    = '{1, 0, 0, 0, 0};
      rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = 8'd0;
`ifdef UPDOWN_BCD_EN
      b_rst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_sat = 1'b0; b_load = 1'b0; b_load_val = 8'd0;
`endif
      cyc();
      cyc();
      chk_en = 1;
      check("reset_count", int'(count), 0);
      check("reset_tc", int'(tc), 0);
      rst = 1'b0;

      en = 1'b1; up = 1'b1; sat = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         check("wrap_count", int'(count), exp_wrap[k]);
         check("wrap_tc", int'(tc), (k == 9) ? 1 : 0);
      end

      en = 1'b0; load = 1'b1; load_val = 8'd2;
      cyc();
      check("load2_count", int'(count), 2);
      load = 1'b0; up = 1'b0; sat = 1'b1; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("downsat_count", int'(count), exp_ds[k]);
         check("downsat_tc", int'(tc), (k >= 1) ? 1 : 0);
      end

      load = 1'b1; load_val = 8'd200; en = 1'b1; up = 1'b1; sat = 1'b0;
      cyc();
      check("clamp_count", int'(count), 9);
      check("clamp_tc", int'(tc), 0);
      load = 1'b0;
      cyc();
      check("after_clamp_count", int'(count), 0);
      check("after_clamp_tc", int'(tc), 1);

      load = 1'b1; load_val = 8'd5; en = 1'b0;
      cyc();
      check("load5_count", int'(count), 5);
      load = 1'b0; en = 1'b1; rst = 1'b1;
      cyc();
      check("midrst_count", int'(count), 0);
      check("midrst_tc", int'(tc), 0);
      rst = 1'b0;
      cyc();
      check("post_rst_count", int'(count), 1);
      en = 1'b0;
      #2 rst = 1'b1;
      #1 check("offedge_rst_hold", int'(count), 1);
      cyc();
      check("offedge_rst_edge", int'(count), 0);
      rst = 1'b0;

      for (int k = 0; k < 600; k++) begin
         cyc();
         rst      = ($urandom_range(0, 59) == 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = 8'($urandom_range(0, 255));
         en       = ($urandom_range(0, 3) != 0);
         up       = ($urandom_range(0, 2) != 0);
         sat      = 1'($urandom_range(0, 1));
      end
      cyc();
      rst = 1'b0; load = 1'b0; en = 1'b0;
      cyc();

`ifdef UPDOWN_BCD_EN
      begin
         int k;
         int pulses;
         b_rst = 1'b0;
         check("bcd_reset", int'(b_bcd), 0);
         check("bcd_valid_reset", int'(b_bcd_valid), 0);

         b_load = 1'b1; b_load_val = 8'd173;
         cyc();
         b_load = 1'b0;
         b_wait(30, k);
         check("bcd173_latency", k, 10);
         check("bcd173_value", int'(b_bcd), 'h173);
         cyc();
         check("bcd_valid_one_cycle", int'(b_bcd_valid), 0);

         b_load = 1'b1; b_load_val = 8'd45;
         cyc();
         b_load = 1'b0;
         cyc(); cyc(); cyc();
         b_load = 1'b1; b_load_val = 8'd200;
         cyc();
         b_load = 1'b0;
         b_wait(30, k);
         check("bcd_inflight_value", int'(b_bcd), 'h045);
         b_wait(30, k);
         check("bcd_final_valid", int'(b_bcd_valid), 1);
         check("bcd_final_value", int'(b_bcd), to_bcd(int'(b_count)));
         check("bcd_final_literal", int'(b_bcd), 'h200);

         b_load = 1'b1; b_load_val = 8'd50;
         cyc();
         b_load = 1'b0;
         cyc(); cyc(); cyc();
         b_rst = 1'b1;
         cyc();
         b_rst = 1'b0;
         check("abort_bcd", int'(b_bcd), 0);
         check("abort_valid", int'(b_bcd_valid), 0);
         pulses = 0;
         for (int j = 0; j < 15; j++) begin
            cyc();
            if (b_bcd_valid) pulses++;
         end
         check("abort_no_pulse", pulses, 0);

         b_load = 1'b1; b_load_val = 8'd99;
         cyc();
         b_load = 1'b0;
         b_wait(30, k);
         check("bcd99_latency", k, 10);
         check("bcd99_value", int'(b_bcd), 'h099);
      end
`endif

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
